// File: rtl/mem_arbiter.sv
//==============================================================================
// mem_arbiter : round-robin arbiter sharing one memory port between
//               instruction fetch and load/store data paths.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;   // 0 = fetch, 1 = data
  logic                pri_q, pri_d;       // 0 = data preferred, 1 = fetch preferred
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic w_d_win;
  logic w_if_win;

  // On a tie pri picks the winner; a lone requester always wins.
  assign w_d_win  = d_req_i  & (~if_req_i | ~pri_q);
  assign w_if_win = if_req_i & (~d_req_i  |  pri_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      pri_q   <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      pri_q   <= pri_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    pri_d    = pri_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    if_gnt_o = 1'b0;
    d_gnt_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_d_win) begin
          d_gnt_o = 1'b1;
          owner_d = 1'b1;
          pri_d   = 1'b1;
          addr_d  = d_addr_i;
          we_d    = d_we_i;
          wdata_d = d_wdata_i;
          state_d = S_ISSUE;
        end else if (w_if_win) begin
          if_gnt_o = 1'b1;
          owner_d  = 1'b0;
          pri_d    = 1'b0;
          addr_d   = if_addr_i;
          we_d     = 1'b0;
          wdata_d  = '0;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: if (mem_gnt_i)    state_d = S_WAIT;
      S_WAIT:  if (mem_rvalid_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_req_o   = (state_q == S_ISSUE);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

  // Responses outside WAIT are dropped so stale or spurious acks never leak out.
  assign if_rvalid_o = mem_rvalid_i & (state_q == S_WAIT) & ~owner_q;
  assign d_rvalid_o  = mem_rvalid_i & (state_q == S_WAIT) &  owner_q;
  assign if_rdata_o  = mem_rdata_i;
  assign d_rdata_o   = mem_rdata_i;

  assign busy_o = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares one single-ported memory between the CPU's instruction-fetch path and its load/store data path. It accepts one transaction at a time, forwards it to the memory port with a request/grant handshake, and routes the memory response back to the requester that owns the transaction. Simultaneous requests are resolved round-robin. The block sits between the core (PC/fetch and data-access logic) and the shared memory model.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width

- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-high
- if_req_i  in  1  fetch request; held until granted
- if_addr_i  in  ADDR_W  fetch address
- if_gnt_o  out  1  fetch request accepted (1-cycle pulse)
- if_rvalid_o  out  1  fetch response valid (1-cycle pulse)
- if_rdata_o  out  DATA_W  fetch response data
- d_req_i  in  1  data request; held until granted
- d_we_i  in  1  1 = write, 0 = read
- d_addr_i  in  ADDR_W  data address
- d_wdata_i  in  DATA_W  write data
- d_gnt_o  out  1  data request accepted (1-cycle pulse)
- d_rvalid_o  out  1  data response valid; also marks write completion
- d_rdata_o  out  DATA_W  data read response
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_gnt_i  in  1  memory accepted request
- mem_rvalid_i  in  1  memory response / write ack
- mem_rdata_i  in  DATA_W  memory read data
- busy_o  out  1  transaction in flight (state != IDLE)

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- Registers: state, owner (0 = IF, 1 = data), pri (0 = data preferred, 1 = IF preferred), addr_q, we_q, wdata_q.
- IDLE:
  - Select a winner combinationally.
    - Only one request high: that requester wins.
    - Both high: pri decides.
  - Pulse the winner's gnt_o.
  - At the edge: capture addr, we and wdata into the _q registers (IF forces we_q = 0, wdata_q = 0); set owner; go to ISSUE.
  - pri flips to prefer the loser: data granted sets pri = 1; IF granted sets pri = 0.
  - No request: stay in IDLE.
- ISSUE:
  - mem_req_o = 1; mem_addr_o, mem_we_o and mem_wdata_o driven from the _q registers and held stable.
  - mem_gnt_i = 1 goes to WAIT; otherwise stay in ISSUE.
- WAIT:
  - mem_req_o = 0.
  - On mem_rvalid_i = 1: the owner's rvalid_o = 1 in the same cycle, then go to IDLE.
- Response routing:
  - if_rdata_o and d_rdata_o both mirror mem_rdata_i.
  - Each rvalid_o = mem_rvalid_i AND state == WAIT AND owner matches.
- No gnt_o is asserted outside IDLE. Requests arriving while busy wait and stay asserted.
- mem_rvalid_i outside WAIT is ignored. The memory must not assert rvalid in the cycle it grants.
- A requester dropping req before grant is legal; no grant is issued.

## Timing
- Reset (rst_i high at an edge):
  - state = IDLE, owner = 0, pri = 0, all _q = 0.
  - Next cycle: all outputs 0 (rdata outputs follow mem_rdata_i).
  - Any in-flight transaction is abandoned; a late mem_rvalid_i is ignored.
- Minimum transaction, with the request presented in IDLE at cycle 0:
  - cycle 0: gnt_o
  - cycle 1: mem_req_o, with mem_gnt_i in the same cycle
  - cycle 2: WAIT, mem_rvalid_i and rvalid_o
  - cycle 3: IDLE, next grant possible
- Peak throughput: one transaction per 3 cycles.
- Each cycle mem_gnt_i is low in ISSUE adds one cycle. Each cycle without mem_rvalid_i in WAIT adds one cycle.
- Round-robin guarantees that under continuous contention, grants alternate data, IF, data, IF, and so on. No starvation.
- busy_o = 1 in ISSUE and WAIT only.

## Test plan
- Single fetch: if_req_i = 1, if_addr_i = 0x10 in IDLE, memory grants immediately and returns 0xDEADBEEF one cycle later.
  - if_gnt_o at cycle 0.
  - mem_req_o = 1, mem_addr_o = 0x10, mem_we_o = 0 at cycle 1.
  - if_rvalid_o = 1, if_rdata_o = 0xDEADBEEF at cycle 2.
  - d_rvalid_o stays 0.
- Data write: d_req_i = 1, d_we_i = 1, d_addr_i = 0x40, d_wdata_i = 0x12345678.
  - mem_we_o = 1, mem_addr_o = 0x40, mem_wdata_o = 0x12345678 held through 3 cycles of mem_gnt_i = 0.
  - d_rvalid_o pulses on the ack.
- Contention: both requests held high for 4 transactions after reset.
  - Grant order is data, IF, data, IF.
  - The grants are exactly one per transaction, each in an IDLE cycle.
- Busy blocking: a fetch is in WAIT with a 5-cycle memory latency while d_req_i rises.
  - d_gnt_o stays 0 until the cycle after if_rvalid_o.
  - The data transaction then starts.
- Reset mid-operation: rst_i = 1 while in WAIT, then the memory asserts mem_rvalid_i the cycle after reset releases.
  - No rvalid_o pulses.
  - busy_o = 0.
  - pri = 0: the next tie goes to data.
- Spurious response: mem_rvalid_i = 1 while in IDLE or ISSUE.
  - No rvalid_o.
  - The FSM stays in its current state.
